// File: rtl/map_arb_pkg.sv
// Shared types and constants for the map tile RAM write arbiter.
// State encoding, default map depth, tile codes and a range-check helper.
package map_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } arb_state_e;

  // 16x12 tile map
  localparam int MAP_DEPTH_DEFAULT = 192;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_BRICK = 3'd1;
  localparam logic [2:0] TILE_STEEL = 3'd2;
  localparam logic [2:0] TILE_WATER = 3'd3;
  localparam logic [2:0] TILE_TREE  = 3'd4;
  localparam logic [2:0] TILE_ICE   = 3'd5;

  function automatic logic tile_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/map_write_arbiter_if.sv
// Requester-side bus of the map write arbiter: packed per-requester
// request/address/data slices and the one-hot grant returned to them.
interface map_write_arbiter_if #(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 15
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            gnt;

  modport master (output req, req_addr, req_data, input gnt);
  modport slave  (input req, req_addr, req_data, output gnt);
endinterface

// File: rtl/map_write_arbiter_rr_arbiter.sv
// Purely combinational N-way round-robin pick: first eligible requester at or
// after ptr_i (wrapping), where masked requesters are not eligible.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0] eligible;
  int unsigned  cand;

  assign eligible = req_i & ~mask_i;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves a latch behind.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= N) cand = cand - N;
      if (!valid_o && eligible[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/map_write_arbiter.sv
// Sole owner of the tile RAM write port: round-robin requester writes plus a bulk FILL.
// Define MAP_ARB_STATS_EN to add saturating per-requester write counters on wr_count.
module map_write_arbiter
  import map_arb_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 15,
  parameter int MAP_DEPTH  = MAP_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  map_write_arbiter_if.slave    bus,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  err_oor,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata
`ifdef MAP_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]   wr_count
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAP_DEPTH - 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [N_REQ-1:0]      rr_gnt;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_valid;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_in_range;

  // The requester whose grant is visible this cycle is masked, so it can update req first.
  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (bus.req),
    .mask_i  (gnt_q),
    .ptr_i   (ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fill_cnt_d   = fill_cnt_q;
    fill_val_d   = fill_val_q;
    gnt_d        = '0;
    we_d         = 1'b0;
    waddr_d      = '0;
    wdata_d      = '0;
    err_d        = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    win_addr     = bus.req_addr[rr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    win_data     = bus.req_data[rr_idx*DATA_WIDTH +: DATA_WIDTH];
    win_in_range = tile_in_range(32'(win_addr), MAP_DEPTH);

    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d    = FILL;
          fill_cnt_d = '0;
          fill_val_d = fill_value;
        end else if (rr_valid) begin
          gnt_d   = rr_gnt;
          we_d    = win_in_range;
          waddr_d = win_addr;
          wdata_d = win_data;
          err_d   = !win_in_range;
          ptr_d   = (rr_idx == IDX_W'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;
        end
      end
      FILL: begin
        // Last fill write is on the bus this cycle: finish instead of writing again.
        if (busy_q && waddr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = fill_cnt_q;
          wdata_d = fill_val_q;
          busy_d  = 1'b1;
          if (fill_cnt_q != LAST_ADDR) fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      fill_cnt_q <= '0;
      fill_val_q <= '0;
      gnt_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fill_cnt_q <= fill_cnt_d;
      fill_val_q <= fill_val_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign err_oor   = err_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;

`ifdef MAP_ARB_STATS_EN
  logic [15:0] wr_cnt_q [N_REQ];

  // NOTE: this small counter array must read zero after reset, so it is reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) wr_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_d[i] && we_d && wr_cnt_q[i] != 16'hFFFF) wr_cnt_q[i] <= wr_cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_wr_count
    assign wr_count[g*16 +: 16] = wr_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter: round-robin order, masking, FILL, range errors,
// mid-fill reset and (with MAP_ARB_STATS_EN) the saturating write counters.
module tb_map_write_arbiter;
  import map_arb_pkg::*;

  localparam int N  = 3;
  localparam int DW = 3;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy, fill_done, err_oor, ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
`ifdef MAP_ARB_STATS_EN
  logic [N*16-1:0] wr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  map_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  map_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAP_DEPTH(192)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .err_oor    (err_oor),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata)
`ifdef MAP_ARB_STATS_EN
    ,
    .wr_count   (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_outs"}, {27'd0, fill_busy, fill_done, err_oor, ram_waddr != 0, ram_wdata != 0}, 32'd0);
  endtask

  logic [N-1:0]  exp_gnt [6];
  logic [AW-1:0] exp_addr[6];

  initial begin
    int bad;
    int busy_cycles;

    rst_n        = 1'b1;
    fill_start   = 1'b0;
    fill_value   = '0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // 1: all three requesting -> 001,010,100 repeating, one write per cycle
    set_req(0, 15'd10, TILE_BRICK);
    set_req(1, 15'd20, TILE_STEEL);
    set_req(2, 15'd30, TILE_WATER);
    bus.req = 3'b111;
    exp_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_addr = '{15'd10, 15'd20, 15'd30, 15'd10, 15'd20, 15'd30};
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(exp_gnt[k]));
      check($sformatf("rr_addr%0d", k), 32'(ram_waddr), 32'(exp_addr[k]));
    end
    check("rr_we", 32'(ram_we), 32'd1);
    check("rr_data", 32'(ram_wdata), 32'(TILE_WATER));
    bus.req = '0;
    tick();
    check_idle_outputs("noreq");

    // 2: single requester, masked while its grant is visible
    set_req(1, 15'd5, 3'b010);
    bus.req = 3'b010;
    tick();
    check("one_gnt", 32'(bus.gnt), 32'b010);
    check("one_we", 32'(ram_we), 32'd1);
    check("one_addr", 32'(ram_waddr), 32'd5);
    check("one_data", 32'(ram_wdata), 32'd2);
    tick();
    check("one_masked_gnt", 32'(bus.gnt), 32'd0);
    check("one_masked_we", 32'(ram_we), 32'd0);
    bus.req = '0;

    // 3: fill beats a pending request; request served right after fill_done
    set_req(0, 15'd7, TILE_TREE);
    bus.req    = 3'b001;
    fill_start = 1'b1;
    fill_value = 3'b001;
    tick();
    fill_start = 1'b0;
    fill_value = TILE_ICE;
    check("fill_start_gnt", 32'(bus.gnt), 32'd0);
    check("fill_start_we", 32'(ram_we), 32'd0);
    bad = 0;
    busy_cycles = 0;
    for (int i = 0; i < 192; i++) begin
      if (i == 50) fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      if (fill_busy) busy_cycles++;
      if (!(ram_we && ram_waddr == AW'(i) && ram_wdata == 3'd1 && bus.gnt == 0 && !fill_done && !err_oor))
        bad++;
    end
    check("fill_seq_bad_cycles", 32'(bad), 32'd0);
    check("fill_busy_cycles", 32'(busy_cycles), 32'd192);
    tick();
    check("fill_done", 32'(fill_done), 32'd1);
    check("fill_done_busy", 32'(fill_busy), 32'd0);
    check("fill_done_we", 32'(ram_we), 32'd0);
    check("fill_done_gnt", 32'(bus.gnt), 32'd0);
    tick();
    check("after_fill_done", 32'(fill_done), 32'd0);
    check("after_fill_gnt", 32'(bus.gnt), 32'b001);
    check("after_fill_addr", 32'(ram_waddr), 32'd7);
    check("after_fill_data", 32'(ram_wdata), 32'(TILE_TREE));
    bus.req = '0;

    // 4: out-of-range address still granted, no write, err pulse
    set_req(2, 15'd192, TILE_ICE);
    bus.req = 3'b100;
    tick();
    check("oor_gnt", 32'(bus.gnt), 32'b100);
    check("oor_err", 32'(err_oor), 32'd1);
    check("oor_we", 32'(ram_we), 32'd0);
    bus.req = '0;
    tick();
    check("oor_err_pulse", 32'(err_oor), 32'd0);
    set_req(2, 15'd191, TILE_ICE);
    bus.req = 3'b100;
    tick();
    check("edge_gnt", 32'(bus.gnt), 32'b100);
    check("edge_we", 32'(ram_we), 32'd1);
    check("edge_addr", 32'(ram_waddr), 32'd191);
    check("edge_err", 32'(err_oor), 32'd0);
    bus.req = '0;
    tick();

    // 5: move pointer off 0, start fill, reset at address 100
    set_req(0, 15'd3, TILE_BRICK);
    bus.req = 3'b001;
    tick();
    check("pre_rst_gnt", 32'(bus.gnt), 32'b001);
    bus.req    = '0;
    fill_start = 1'b1;
    fill_value = TILE_STEEL;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i <= 100; i++) tick();
    check("rst_fill_addr", 32'(ram_waddr), 32'd100);
    check("rst_fill_busy", 32'(fill_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fill_done || fill_busy || ram_we) bad++;
    end
    check("rst_no_resume", 32'(bad), 32'd0);
    set_req(0, 15'd11, TILE_BRICK);
    set_req(1, 15'd21, TILE_STEEL);
    set_req(2, 15'd31, TILE_WATER);
    bus.req = 3'b111;
    tick();
    check("rst_ptr_gnt", 32'(bus.gnt), 32'b001);
    check("rst_ptr_addr", 32'(ram_waddr), 32'd11);
    bus.req = '0;
    tick();

`ifdef MAP_ARB_STATS_EN
    // 6: three in-range writes + one out-of-range from requester 0, then saturation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("cnt_reset", 32'(wr_count), 32'd0);
    set_req(0, 15'd40, TILE_BRICK);
    bus.req = 3'b001;
    for (int i = 0; i < 5; i++) tick();
    check("cnt_third_gnt", 32'(bus.gnt), 32'b001);
    set_req(0, 15'd200, TILE_BRICK);
    tick();
    tick();
    check("cnt_oor_err", 32'(err_oor), 32'd1);
    bus.req = '0;
    tick();
    check("cnt_req0", 32'(wr_count[15:0]), 32'd3);
    check("cnt_req1", 32'(wr_count[31:16]), 32'd0);
    dut.wr_cnt_q[0] = 16'hFFFF;
    set_req(0, 15'd1, TILE_BRICK);
    bus.req = 3'b001;
    tick();
    bus.req = '0;
    tick();
    check("cnt_saturate", 32'(wr_count[15:0]), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
